// File: rtl/if_id_pkg.sv
// Shared widths, the bubble instruction and the held-entry layout for the IF/ID boundary.
package if_id_pkg;

    localparam int IF_ID_INSTR_W = 16;
    localparam int IF_ID_PC_W    = 16;
    localparam logic [IF_ID_INSTR_W-1:0] IF_ID_NOP = 16'h0800;

    typedef struct packed {
        logic                     valid;
        logic [IF_ID_PC_W-1:0]    pc;
        logic [IF_ID_INSTR_W-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_entry_reg.sv
// One loadable {valid, pc, instr} holding register with synchronous clear.
// Load takes effect on the next edge; clear (or reset) wins over load and parks the entry as a NOP bubble.
module if_id_entry_reg
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = IF_ID_INSTR_W,
    parameter int                 PC_W      = IF_ID_PC_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               d_valid,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               q_valid,
    output logic [PC_W-1:0]    q_pc,
    output logic [INSTR_W-1:0] q_instr
);

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t entry_d;
    entry_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else if (load) begin
            entry_d = '{valid: d_valid, pc: d_pc, instr: d_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_valid = entry_q.valid;
    assign q_pc    = entry_q.pc;
    assign q_instr = entry_q.instr;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID boundary with a two-entry skid buffer: accepted beat (pc already incremented) shows one cycle later.
// in_ready is a flop, dropping only while both entries are full; flush turns everything held into a bubble.
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = IF_ID_INSTR_W,
    parameter int                 PC_W      = IF_ID_PC_W,
    parameter logic [PC_W-1:0]    PC_INC    = PC_W'(1),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    logic               main_vld, skid_vld;
    logic [PC_W-1:0]    main_pc, skid_pc;
    logic [INSTR_W-1:0] main_instr, skid_instr;

    logic               main_load, main_clr, main_from_skid;
    logic               skid_load, skid_clr;
    logic [PC_W-1:0]    main_d_pc;
    logic [INSTR_W-1:0] main_d_instr;
    logic               main_nxt, skid_nxt;
    logic [1:0]         occ_d;
    logic               in_ready_d, in_ready_q;
    logic               accept, deliver;
    logic [PC_W-1:0]    new_pc;

    assign accept  = in_valid & in_ready_q;
    assign deliver = main_vld & out_ready;
    assign new_pc  = in_pc + PC_INC;

    // Skid only ever fills behind a stalled main, so it is always the older beat.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_vld) begin
            main_load = accept;
        end else if (deliver) begin
            if (skid_vld) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end

        main_d_pc    = main_from_skid ? skid_pc    : new_pc;
        main_d_instr = main_from_skid ? skid_instr : in_instr;

        main_nxt   = main_clr ? 1'b0 : (main_load ? 1'b1 : main_vld);
        skid_nxt   = skid_clr ? 1'b0 : (skid_load ? 1'b1 : skid_vld);
        occ_d      = {1'b0, main_nxt} + {1'b0, skid_nxt};
        in_ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    if_id_entry_reg #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (main_clr),
        .load    (main_load),
        .d_valid (1'b1),
        .d_pc    (main_d_pc),
        .d_instr (main_d_instr),
        .q_valid (main_vld),
        .q_pc    (main_pc),
        .q_instr (main_instr)
    );

    if_id_entry_reg #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (skid_clr),
        .load    (skid_load),
        .d_valid (1'b1),
        .d_pc    (new_pc),
        .d_instr (in_instr),
        .q_valid (skid_vld),
        .q_pc    (skid_pc),
        .q_instr (skid_instr)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_pc    = main_vld ? main_pc    : '0;
    assign out_instr = main_vld ? main_instr : NOP_INSTR;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
Parametrised IF/ID pipeline boundary register with a valid/ready handshake and a two-entry skid buffer. It sits between instruction fetch and decode. It forwards the fetched PC, already incremented, together with the instruction word. Unlike a plain hold/bubble latch, it absorbs one extra beat when decode stalls, keeps in_ready registered so there is no combinational ready path back to fetch, and supports a single-cycle flush that injects a NOP bubble.

Parameters:
- INSTR_W, 16, instruction word width.
- PC_W, 16, program-counter width.
- PC_INC, 1, constant added to the accepted PC before it is presented downstream (PC_W bits, wraps modulo 2^PC_W).
- NOP_INSTR, 16'h0800, instruction presented whenever out_valid=0 (INSTR_W bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/jump redirect).
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  block can accept a beat; driven directly from a register.
- in_pc  in  PC_W  PC of the fetched instruction.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode beat valid.
- out_ready  in  1  decode accepts the beat.
- out_pc  out  PC_W  in_pc+PC_INC of the presented beat.
- out_instr  out  INSTR_W  presented instruction.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main entry (drives the outputs) and skid entry. Each entry is {valid, pc, instr}. The stored pc is in_pc+PC_INC, computed at accept time, truncated to PC_W, with wrap 16'hFFFF+1 -> 0.
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- Reset (rst=1 at an edge): both entries invalid; out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, occupancy=0. rst overrides flush and all handshakes.
- Invalid output: whenever out_valid=0, out_pc=0 and out_instr=NOP_INSTR. These values are forced, not left stale.
- States (occupancy):
  - EMPTY(0): accept -> ONE.
  - ONE(1), main valid:
    - deliver & accept -> ONE with new data.
    - deliver only -> EMPTY.
    - accept without deliver -> TWO; beat goes to skid.
  - TWO(2): in_ready=0, so no accept is possible.
    - deliver -> ONE; skid moves into main and skid is cleared.
- in_ready next = (next occupancy < 2), registered. So in_ready=0 exactly while TWO.
- Latency: an accepted beat appears on the outputs the cycle after acceptance when main is free or being delivered. Throughput is one beat per cycle while out_ready=1.
- Ordering: strictly in order. The skid entry is always older than any newly accepted beat. In TWO, a deliver never also loads input.
- Flush (rst=0, flush=1 at an edge):
  - Both entries are invalidated; next cycle occupancy=0, out_valid=0, NOP/0 outputs, in_ready=1.
  - An accept coinciding with flush is consumed and discarded; fetch sees the handshake complete.
  - A deliver coinciding with flush completes normally; decode takes the current beat.
- out_ready high with out_valid low has no effect. in_valid low with in_ready high has no effect.
- Out-of-range values are not defined, since widths are exact.

Decomposition:
- Shared package if_id_pkg: INSTR_W/PC_W defaults, NOP_INSTR constant, and an entry struct typedef {valid, pc, instr}.
- One natural sub-module: if_id_entry_reg, a single loadable entry with synchronous clear. It is instantiated twice, as main and skid.
- Occupancy/next-state logic lives in the top.

Test Plan:
- Reset/idle: rst=1 for 2 cycles -> out_valid=0, out_pc=0, out_instr=16'h0800, in_ready=1, occupancy=0.
- Streaming: out_ready=1, in_pc=0x0010,0x0011,0x0012 on consecutive cycles -> out_pc 0x0011,0x0012,0x0013 each one cycle later, no gaps.
- Stall/skid:
  - Accept A (pc 0x20), then B (pc 0x21) with out_ready=0 -> occupancy=2, in_ready=0, out_pc=0x21 held.
  - Raise out_ready -> A then B delivered in order, next out_pc=0x22.
  - in_ready returns to 1 after the first deliver.
- Flush while TWO, with in_valid=1 -> next cycle out_valid=0, out_instr=16'h0800, occupancy=0, in_ready=1; neither held beat nor new beat is ever delivered.
- Wrap: in_pc=16'hFFFF, instr=16'h1234 -> out_pc=16'h0000, out_instr=16'h1234.
- Reset mid-stall with occupancy=2 and flush=1 -> next cycle matches the reset state; the next accepted beat is the first delivered.
